spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  SPI master sequencer between the TX/RX FIFOs and the SPI pins in the APB SPI subsystem.
//  Pops words from TX FIFO, shifts them MSB-first on MOSI (mode 0), captures MISO, pushes results to RX FIFO.
//  Owns SCLK generation, SS_n framing, back-to-back transfers and RX overflow status for the status register.
// PARAMETERS
//  DWIDTH   8  frame/word width in bits (>=2)
//  CLK_DIV  2  PCLK cycles per SCLK half-period (>=1); SCLK period = 2*CLK_DIV PCLK
// PORTS
//  PCLK      in   1       system clock; all logic on rising edge
//  PRESETn   in   1       asynchronous, active-low reset
//  enable    in   1       control reg bit: start/continue transfers while high
//  tx_empty  in   1       TX FIFO empty flag
//  tx_data   in   DWIDTH  TX FIFO head word (valid when !tx_empty, show-ahead)
//  tx_rd     out  1       1-cycle pop strobe to TX FIFO
//  rx_full   in   1       RX FIFO full flag
//  rx_wr     out  1       1-cycle push strobe to RX FIFO
//  rx_data   out  DWIDTH  received word, valid with rx_wr
//  ovf_clr   in   1       clears rx_ovf
//  rx_ovf    out  1       sticky: received word dropped because RX FIFO full
//  busy      out  1       high in any state other than IDLE
//  SCLK      out  1       SPI clock, idle low
//  MOSI      out  1       SPI data out
//  MISO      in   1       SPI data in
//  SS_n      out  1       slave select, active low
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): state=IDLE, SCLK=0, MOSI=0, SS_n=1, tx_rd=0, rx_wr=0,
//   rx_data=0, rx_ovf=0, busy=0, all counters/shift regs=0.
//  FSM IDLE -> LOAD -> SHIFT -> DONE -> (LOAD | IDLE).
//  IDLE: enable && !tx_empty -> LOAD; else stay.
//  LOAD (1 cycle): tx_rd=1, tx_shift<=tx_data, MOSI<=tx_data[DWIDTH-1], SS_n<=0, div_cnt=0, bit_cnt=0.
//  SHIFT: div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 SCLK toggles, div_cnt wraps to 0.
//   rising SCLK edge: rx_shift <= {rx_shift[DWIDTH-2:0], MISO}.
//   falling SCLK edge: bit_cnt++; if bit_cnt==DWIDTH-1 -> DONE, else shift tx_shift left, MOSI<=next bit.
//   SHIFT lasts exactly 2*CLK_DIV*DWIDTH cycles; SCLK ends low.
//  DONE (1 cycle): if !rx_full: rx_wr=1, rx_data<=rx_shift; else rx_wr=0, rx_ovf<=1, word discarded.
//   next: enable && !tx_empty -> LOAD with SS_n held low (continuous frame); else SS_n<=1, -> IDLE.
//  Frame-to-frame gap at back-to-back: 2 PCLK (DONE+LOAD); SCLK stays low during gap.
//  enable dropped mid-frame: current word completes and is pushed; then IDLE.
//  tx_empty rising mid-frame: no effect until DONE.
//  ovf_clr and overflow set in same cycle: set wins (rx_ovf=1).
//  tx_rd only in LOAD, rx_wr only in DONE; never both high same cycle.
//  MOSI holds last bit after frame until next LOAD; MOSI value when SS_n=1 is don't-care for slaves.
// STRUCTURE
//  spi_pkg: typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_state_t; SCLK idle level constant.
//  Sub-module spi_clk_gen (params CLK_DIV): div_cnt, SCLK register, rise/fall strobes, run/clear inputs.
//  Top: FSM, bit counter ($clog2(DWIDTH) bits), TX/RX shift registers, rx_ovf flag.
// TESTING (DWIDTH=8, CLK_DIV=2)
//  1 Loopback MISO=MOSI, TX head 0xA5, enable=1 -> tx_rd 1 pulse, SCLK period 4 PCLK, 8 rising edges,
//    MOSI 1,0,1,0,0,1,0,1, rx_wr with rx_data=0xA5, SS_n low for 32 SHIFT cycles + DONE, then high.
//  2 TX FIFO holds 0x3C,0xFF, enable=1 -> SS_n low continuously across both frames, 2-cycle SCLK-low gap,
//    rx_wr twice with 0x3C then 0xFF (loopback); busy=0 after second DONE.
//  3 rx_full=1 during DONE of 0x81 -> rx_wr=0, rx_ovf=1; ovf_clr pulse -> rx_ovf=0; same-cycle set+clr -> 1.
//  4 enable deasserted at bit 3 of 0x55 -> frame finishes (8 SCLK), rx_wr, SS_n=1, IDLE; no second tx_rd.
//  5 PRESETn asserted at bit 5 -> same cycle SS_n=1, SCLK=0, busy=0; after release, enable=1 restarts
//    with fresh LOAD of next TX head, full 8-bit frame.
//  6 MISO driven constant 1 with TX 0x00 -> rx_data=0xFF, MOSI=0 throughout; CLK_DIV=1 rerun: period 2 PCLK.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } spi_state_t;

    localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV cycles while run is high and
// flags the cycle before each SCLK edge with a one-cycle rise/fall strobe.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic run,
    input  logic clear,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          terminal;

    assign terminal = run && (div_cnt == DIV_LAST);
    assign rise     = terminal && (sclk == SCLK_IDLE);
    assign fall     = terminal && (sclk != SCLK_IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_cnt <= '0;
            sclk    <= SCLK_IDLE;
        end else if (clear) begin
            div_cnt <= '0;
            sclk    <= SCLK_IDLE;
        end else if (run) begin
            if (terminal) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master (mode 0): pops TX FIFO words, shifts them MSB-first on MOSI,
// captures MISO and pushes the received word to the RX FIFO.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              enable,
    input  logic              tx_empty,
    input  logic [DWIDTH-1:0] tx_data,
    output logic              tx_rd,
    input  logic              rx_full,
    output logic              rx_wr,
    output logic [DWIDTH-1:0] rx_data,
    input  logic              ovf_clr,
    output logic              rx_ovf,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SS_n
);

    localparam int BW = $clog2(DWIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(DWIDTH - 1);

    spi_state_t        state, next_state;
    logic [BW-1:0]     bit_cnt;
    logic [DWIDTH-2:0] tx_shift;
    logic [DWIDTH-1:0] rx_shift;
    logic              run, sclk_rise, sclk_fall, last_bit, ovf_set;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .run     (run),
        .clear   (!run),
        .sclk    (SCLK),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    assign last_bit = sclk_fall && (bit_cnt == BIT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (enable && !tx_empty) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:    next_state = (enable && !tx_empty) ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_rd   = 1'b0;
        rx_wr   = 1'b0;
        ovf_set = 1'b0;
        busy    = (state != IDLE);
        run     = (state == SHIFT);
        if (state == LOAD) tx_rd = 1'b1;
        if (state == DONE) begin
            rx_wr   = !rx_full;
            ovf_set = rx_full;
        end
    end

    // The MSB goes straight to MOSI at LOAD, so tx_shift only holds the
    // remaining DWIDTH-1 bits. rx_data is latched on the final falling edge
    // so it is already valid in the DONE cycle alongside rx_wr.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            MOSI     <= 1'b0;
            SS_n     <= 1'b1;
        end else begin
            unique case (state)
                LOAD: begin
                    tx_shift <= tx_data[DWIDTH-2:0];
                    MOSI     <= tx_data[DWIDTH-1];
                    SS_n     <= 1'b0;
                    bit_cnt  <= '0;
                end
                SHIFT: begin
                    if (sclk_rise) rx_shift <= {rx_shift[DWIDTH-2:0], MISO};
                    if (sclk_fall) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            rx_data <= rx_shift;
                        end else begin
                            MOSI     <= tx_shift[DWIDTH-2];
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end
                DONE: if (next_state == IDLE) SS_n <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)     rx_ovf <= 1'b0;
        else if (ovf_set) rx_ovf <= 1'b1;
        else if (ovf_clr) rx_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl (DWIDTH=8, CLK_DIV=2 and 1).
module tb_spi_master_ctrl;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    logic       enable = 1'b0, rx_full = 1'b0, ovf_clr = 1'b0;
    logic       tx_empty, tx_rd, rx_wr, rx_ovf, busy, SCLK, MOSI, MISO, SS_n;
    logic [7:0] tx_data, rx_data;
    logic       loop = 1'b1, miso_val = 1'b0;

    logic [7:0] txm [8];
    int         wr_ptr = 0, rd_ptr = 0;
    assign tx_empty = (wr_ptr == rd_ptr);
    assign tx_data  = txm[rd_ptr % 8];
    assign MISO     = loop ? MOSI : miso_val;
    always @(posedge PCLK) if (tx_rd) rd_ptr <= rd_ptr + 1;

    spi_master_ctrl #(.DWIDTH(8), .CLK_DIV(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .tx_empty(tx_empty),
        .tx_data(tx_data), .tx_rd(tx_rd), .rx_full(rx_full), .rx_wr(rx_wr),
        .rx_data(rx_data), .ovf_clr(ovf_clr), .rx_ovf(rx_ovf), .busy(busy),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
    );

    logic       en1 = 1'b0;
    logic [7:0] tx1_data = 8'h00;
    int         tx1_wr = 0, tx1_pop = 0;
    logic       tx1_empty, tx1_rd, rx1_wr, rx1_ovf, busy1, sclk1, mosi1, ss1_n;
    logic [7:0] rx1_data;
    assign tx1_empty = (tx1_wr == tx1_pop);
    always @(posedge PCLK) if (tx1_rd) tx1_pop <= tx1_pop + 1;

    spi_master_ctrl #(.DWIDTH(8), .CLK_DIV(1)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .enable(en1), .tx_empty(tx1_empty),
        .tx_data(tx1_data), .tx_rd(tx1_rd), .rx_full(1'b0), .rx_wr(rx1_wr),
        .rx_data(rx1_data), .ovf_clr(1'b0), .rx_ovf(rx1_ovf), .busy(busy1),
        .SCLK(sclk1), .MOSI(mosi1), .MISO(mosi1), .SS_n(ss1_n)
    );

    int         cyc = 0, txrd_cnt = 0, rxwr_cnt = 0, rise_cnt = 0, ss_low_cnt = 0, mosi_hi_cnt = 0;
    int         rise_cyc [64];
    logic [7:0] rx_log [16];
    logic [7:0] mosi_log = 8'h00;
    logic       sclk_prev = 1'b0, sclk1_prev = 1'b0;
    int         rise1_cnt = 0, rise1_last = 0, rise1_prev = 0, rx1_cnt = 0;
    logic [7:0] rx1_last = 8'h00;

    always @(negedge PCLK) begin
        cyc++;
        if (tx_rd) txrd_cnt++;
        if (rx_wr) begin
            rx_log[rxwr_cnt % 16] = rx_data;
            rxwr_cnt++;
        end
        if (SCLK && !sclk_prev) begin
            rise_cyc[rise_cnt % 64] = cyc;
            rise_cnt++;
            mosi_log = {mosi_log[6:0], MOSI};
        end
        sclk_prev = SCLK;
        if (!SS_n) begin
            ss_low_cnt++;
            if (MOSI) mosi_hi_cnt++;
        end
        if (sclk1 && !sclk1_prev) begin
            rise1_prev = rise1_last;
            rise1_last = cyc;
            rise1_cnt++;
        end
        sclk1_prev = sclk1;
        if (rx1_wr) begin
            rx1_last = rx1_data;
            rx1_cnt++;
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        txm[wr_ptr % 8] = d;
        wr_ptr++;
    endtask

    // Waits for busy to rise (if not already) then fall; to=1 when either bound expires.
    task automatic wait_frames(output bit to);
        int n;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        to = !busy;
        n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        if (busy) to = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (SS_n !== 1'b1) begin n_err++; $display("FAIL reset_ss_n got=%b want=1", SS_n); end
        n_cmp++; if (SCLK !== 1'b0) begin n_err++; $display("FAIL reset_sclk got=%b want=0", SCLK); end
        n_cmp++; if (MOSI !== 1'b0) begin n_err++; $display("FAIL reset_mosi got=%b want=0", MOSI); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if ({tx_rd, rx_wr, rx_ovf} !== 3'b000) begin n_err++; $display("FAIL reset_strobes got=%b want=000", {tx_rd, rx_wr, rx_ovf}); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        int b_rd, b_wr, b_rise, b_ss;
        bit to;
        b_rd = txrd_cnt; b_wr = rxwr_cnt; b_rise = rise_cnt; b_ss = ss_low_cnt;
        loop = 1'b1;
        push(8'hA5);
        enable = 1'b1;
        wait_frames(to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL lb_timeout got=%b want=0", to); end
        n_cmp++; if (txrd_cnt - b_rd !== 1) begin n_err++; $display("FAIL lb_tx_rd got=%0d want=1", txrd_cnt - b_rd); end
        n_cmp++; if (rise_cnt - b_rise !== 8) begin n_err++; $display("FAIL lb_rises got=%0d want=8", rise_cnt - b_rise); end
        n_cmp++; if (rise_cyc[(rise_cnt-1)%64] - rise_cyc[(rise_cnt-2)%64] !== 4) begin
            n_err++; $display("FAIL lb_period got=%0d want=4", rise_cyc[(rise_cnt-1)%64] - rise_cyc[(rise_cnt-2)%64]); end
        n_cmp++; if (mosi_log !== 8'hA5) begin n_err++; $display("FAIL lb_mosi_bits got=%h want=a5", mosi_log); end
        n_cmp++; if (rxwr_cnt - b_wr !== 1) begin n_err++; $display("FAIL lb_rx_wr got=%0d want=1", rxwr_cnt - b_wr); end
        n_cmp++; if (rx_log[(rxwr_cnt-1)%16] !== 8'hA5) begin n_err++; $display("FAIL lb_rx_data got=%h want=a5", rx_log[(rxwr_cnt-1)%16]); end
        n_cmp++; if (ss_low_cnt - b_ss !== 33) begin n_err++; $display("FAIL lb_ss_low got=%0d want=33", ss_low_cnt - b_ss); end
        n_cmp++; if (SS_n !== 1'b1) begin n_err++; $display("FAIL lb_ss_end got=%b want=1", SS_n); end
    endtask

    task automatic test_back_to_back();
        int b_rd, b_wr, b_rise, b_ss;
        bit to;
        b_rd = txrd_cnt; b_wr = rxwr_cnt; b_rise = rise_cnt; b_ss = ss_low_cnt;
        push(8'h3C);
        push(8'hFF);
        wait_frames(to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got=%b want=0", to); end
        n_cmp++; if (txrd_cnt - b_rd !== 2) begin n_err++; $display("FAIL b2b_tx_rd got=%0d want=2", txrd_cnt - b_rd); end
        n_cmp++; if (rxwr_cnt - b_wr !== 2) begin n_err++; $display("FAIL b2b_rx_wr got=%0d want=2", rxwr_cnt - b_wr); end
        n_cmp++; if (rx_log[b_wr%16] !== 8'h3C) begin n_err++; $display("FAIL b2b_rx0 got=%h want=3c", rx_log[b_wr%16]); end
        n_cmp++; if (rx_log[(b_wr+1)%16] !== 8'hFF) begin n_err++; $display("FAIL b2b_rx1 got=%h want=ff", rx_log[(b_wr+1)%16]); end
        n_cmp++; if (rise_cnt - b_rise !== 16) begin n_err++; $display("FAIL b2b_rises got=%0d want=16", rise_cnt - b_rise); end
        n_cmp++; if (rise_cyc[(b_rise+8)%64] - rise_cyc[(b_rise+7)%64] !== 6) begin
            n_err++; $display("FAIL b2b_gap got=%0d want=6", rise_cyc[(b_rise+8)%64] - rise_cyc[(b_rise+7)%64]); end
        n_cmp++; if (ss_low_cnt - b_ss !== 67) begin n_err++; $display("FAIL b2b_ss_low got=%0d want=67", ss_low_cnt - b_ss); end
        n_cmp++; if ({busy, SS_n} !== 2'b01) begin n_err++; $display("FAIL b2b_end got=%b want=01", {busy, SS_n}); end
    endtask

    task automatic test_overflow();
        int b_wr;
        bit to;
        b_wr = rxwr_cnt;
        rx_full = 1'b1;
        push(8'h81);
        wait_frames(to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL ovf_timeout got=%b want=0", to); end
        n_cmp++; if (rxwr_cnt - b_wr !== 0) begin n_err++; $display("FAIL ovf_rx_wr got=%0d want=0", rxwr_cnt - b_wr); end
        n_cmp++; if (rx_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b want=1", rx_ovf); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++; if (rx_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b want=0", rx_ovf); end
        ovf_clr = 1'b1;
        push(8'h18);
        wait_frames(to);
        n_cmp++; if (rx_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got=%b want=1", rx_ovf); end
        ovf_clr = 1'b0;
        rx_full = 1'b0;
        tick();
    endtask

    task automatic test_enable_drop();
        int b_rd, b_wr, b_rise, n;
        bit to;
        b_rd = txrd_cnt; b_wr = rxwr_cnt; b_rise = rise_cnt;
        push(8'h55);
        push(8'h66);
        n = 0;
        while (rise_cnt - b_rise < 3 && n < 200) begin tick(); n++; end
        enable = 1'b0;
        wait_frames(to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL endrop_timeout got=%b want=0", to); end
        n_cmp++; if (txrd_cnt - b_rd !== 1) begin n_err++; $display("FAIL endrop_tx_rd got=%0d want=1", txrd_cnt - b_rd); end
        n_cmp++; if (rise_cnt - b_rise !== 8) begin n_err++; $display("FAIL endrop_rises got=%0d want=8", rise_cnt - b_rise); end
        n_cmp++; if (rxwr_cnt - b_wr !== 1) begin n_err++; $display("FAIL endrop_rx_wr got=%0d want=1", rxwr_cnt - b_wr); end
        n_cmp++; if (rx_log[b_wr%16] !== 8'h55) begin n_err++; $display("FAIL endrop_rx_data got=%h want=55", rx_log[b_wr%16]); end
        n_cmp++; if ({busy, SS_n} !== 2'b01) begin n_err++; $display("FAIL endrop_end got=%b want=01", {busy, SS_n}); end
    endtask

    task automatic test_reset_midframe();
        int b_rd, b_wr, b_rise, n;
        bit to;
        b_rise = rise_cnt;
        enable = 1'b1;
        n = 0;
        while (rise_cnt - b_rise < 5 && n < 200) begin tick(); n++; end
        PRESETn = 1'b0;
        enable = 1'b0;
        #1;
        n_cmp++; if (SS_n !== 1'b1) begin n_err++; $display("FAIL rstmid_ss_n got=%b want=1", SS_n); end
        n_cmp++; if (SCLK !== 1'b0) begin n_err++; $display("FAIL rstmid_sclk got=%b want=0", SCLK); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        n_cmp++; if (MOSI !== 1'b0) begin n_err++; $display("FAIL rstmid_mosi got=%b want=0", MOSI); end
        push(8'hC3);
        repeat (2) tick();
        PRESETn = 1'b1;
        tick();
        b_rd = txrd_cnt; b_wr = rxwr_cnt; b_rise = rise_cnt;
        enable = 1'b1;
        wait_frames(to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rstmid_timeout got=%b want=0", to); end
        n_cmp++; if (txrd_cnt - b_rd !== 1) begin n_err++; $display("FAIL rstmid_tx_rd got=%0d want=1", txrd_cnt - b_rd); end
        n_cmp++; if (rise_cnt - b_rise !== 8) begin n_err++; $display("FAIL rstmid_rises got=%0d want=8", rise_cnt - b_rise); end
        n_cmp++; if (rx_log[b_wr%16] !== 8'hC3) begin n_err++; $display("FAIL rstmid_rx_data got=%h want=c3", rx_log[b_wr%16]); end
    endtask

    task automatic test_miso_ones();
        int b_wr, b_hi, b_rise, n;
        bit to;
        b_wr = rxwr_cnt; b_hi = mosi_hi_cnt; b_rise = rise_cnt;
        loop = 1'b0;
        miso_val = 1'b1;
        push(8'h00);
        wait_frames(to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL ones_timeout got=%b want=0", to); end
        n_cmp++; if (rx_log[b_wr%16] !== 8'hFF) begin n_err++; $display("FAIL ones_rx_data got=%h want=ff", rx_log[b_wr%16]); end
        n_cmp++; if (mosi_hi_cnt - b_hi !== 0) begin n_err++; $display("FAIL ones_mosi_high got=%0d want=0", mosi_hi_cnt - b_hi); end
        n_cmp++; if (rise_cnt - b_rise !== 8) begin n_err++; $display("FAIL ones_rises got=%0d want=8", rise_cnt - b_rise); end
        enable = 1'b0;
        b_wr = rx1_cnt; b_rise = rise1_cnt;
        tx1_data = 8'h5A;
        tx1_wr++;
        en1 = 1'b1;
        n = 0;
        while (rx1_cnt == b_wr && n < 200) begin tick(); n++; end
        en1 = 1'b0;
        repeat (2) tick();
        n_cmp++; if (rx1_cnt - b_wr !== 1) begin n_err++; $display("FAIL div1_rx_wr got=%0d want=1", rx1_cnt - b_wr); end
        n_cmp++; if (rx1_last !== 8'h5A) begin n_err++; $display("FAIL div1_rx_data got=%h want=5a", rx1_last); end
        n_cmp++; if (rise1_cnt - b_rise !== 8) begin n_err++; $display("FAIL div1_rises got=%0d want=8", rise1_cnt - b_rise); end
        n_cmp++; if (rise1_last - rise1_prev !== 2) begin n_err++; $display("FAIL div1_period got=%0d want=2", rise1_last - rise1_prev); end
        n_cmp++; if ({busy1, ss1_n, rx1_ovf} !== 3'b010) begin n_err++; $display("FAIL div1_end got=%b want=010", {busy1, ss1_n, rx1_ovf}); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_overflow();
        test_enable_drop();
        test_reset_midframe();
        test_miso_ones();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
